dma_axi_ctrl: RTL and testbench
===============================

DMA_AXI_CTRL -- requirements
Module: dma_axi_ctrl

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, meaning the maximum beats per AXI burst and the internal FIFO depth; legal values are powers of 2 from 1 to 16.
REQ-002 SHALL have one clock and a synchronous, active-high reset: hclk is the clock and hreset is the reset.
REQ-003 hclk  input  1  rising-edge clock for all state.
REQ-004 hreset  input  1  synchronous active-high reset.
REQ-005 dma_axi_start  input  1  transfer request, sampled only in IDLE.
REQ-006 dma_cfg_saddr  input  32  source byte address; bits [1:0] are ignored and treated as 0.
REQ-007 dma_cfg_daddr  input  32  destination byte address; bits [1:0] are ignored and treated as 0.
REQ-008 dma_cfg_number  input  14  transfer length in 32-bit words.
REQ-009 dma_axi_done  output  1  level signal: high when idle and ready to accept new configuration.
REQ-010 dma_err  output  1  sticky error flag, cleared by the next accepted start.
REQ-011 AR channel: axi_arvalid out 1; axi_arready in 1; axi_araddr out 32; axi_arlen out 8; axi_arsize out 3; axi_arburst out 2.
REQ-012 R channel: axi_rvalid in 1; axi_rready out 1; axi_rdata in 32; axi_rresp in 2; axi_rlast in 1.
REQ-013 AW channel: axi_awvalid out 1; axi_awready in 1; axi_awaddr out 32; axi_awlen out 8; axi_awsize out 3; axi_awburst out 2.
REQ-014 W channel: axi_wvalid out 1; axi_wready in 1; axi_wdata out 32; axi_wstrb out 4; axi_wlast out 1.
REQ-015 B channel: axi_bvalid in 1; axi_bready out 1; axi_bresp in 2.

Function
REQ-016 SHALL implement the FSM IDLE -> RD_ADDR -> RD_DATA -> WR_ADDR -> WR_DATA -> WR_RESP -> (RD_ADDR if words remain, else IDLE).
REQ-017 In IDLE, a cycle with dma_axi_start=1 SHALL latch saddr, daddr and number, clear dma_err, and set dma_axi_done=0 on the next cycle.
REQ-018 A start with dma_cfg_number=0 SHALL issue no AXI traffic: dma_axi_done drops for exactly one cycle, then returns high.
REQ-019 Burst length SHALL be len = min(MAX_BURST, remaining, 1024-rd_ptr[11:2], 1024-wr_ptr[11:2]), so no read or write burst crosses a 4KB boundary; the read and write bursts for one chunk use the same len.
REQ-020 Fixed AXI fields: arlen and awlen = len-1; arsize and awsize = 3'b010; arburst and awburst = 2'b01 (INCR); wstrb = 4'hF.
REQ-021 Every valid SHALL stay asserted, with its payload stable, until the matching ready is sampled high; no valid SHALL depend combinationally on its ready.
REQ-022 RD_DATA: rready=1; each rvalid&rready beat SHALL push rdata into the FIFO; exit on the beat with rlast=1. A beat count that mismatches rlast SHALL set dma_err.
REQ-023 WR_DATA: wdata comes from the FIFO head, in read order; wlast=1 on beat len; exit after the last wvalid&wready.
REQ-024 WR_RESP: bready=1; on bvalid, rd_ptr and wr_ptr advance by len*4 and remaining decreases by len.
REQ-025 A nonzero rresp on any beat, or a nonzero bresp, SHALL set dma_err; the block then finishes the current AXI transaction (drains all R beats, or takes B) and goes to IDLE without issuing further bursts.
REQ-026 Only one AXI transaction SHALL be outstanding at a time; AR and AW SHALL never be valid in the same cycle.
REQ-027 dma_axi_start SHALL be ignored outside IDLE; configuration inputs SHALL be sampled only at start.
REQ-028 dma_axi_done SHALL rise in the cycle after the final B handshake, or after an abort completes.
REQ-029 Address pointers SHALL wrap modulo 2^32.

Reset
REQ-030 While hreset=1: state=IDLE, dma_axi_done=1, dma_err=0, every valid/ready output=0, FIFO empty, counters=0.
REQ-031 Asserting hreset mid-transfer SHALL abandon the transfer immediately; post-reset AXI protocol consistency is the system's responsibility.

Verification
REQ-032 saddr=0x1000, daddr=0x2000, number=40 -> bursts of 16/16/8 (arlen 15,15,7); destination memory equals source; done high after the 3rd B.
REQ-033 saddr=0x0FF8, daddr=0x3000, number=5 -> first burst len=2 (4KB edge), second len=3 at 0x1000/0x3008.
REQ-034 number=0 -> no arvalid or awvalid; done low for exactly one cycle.
REQ-035 rresp=2'b10 on beat 3 of the first burst -> all 16 R beats drained, no AW issued, dma_err=1, done=1; the next start clears dma_err.
REQ-036 Random arready/rvalid/awready/wready/bvalid stalls at 0-5 cycles, number=100 -> data correct; valid/payload held stable through every stall.
REQ-037 hreset asserted in WR_DATA -> next cycle done=1, wvalid=0, dma_err=0; a new start with number=4 then completes correctly.

Source files
------------

// File: rtl/dma_axi_ctrl.sv
// rtl/dma_axi_ctrl.sv - memory-to-memory AXI DMA: one read burst into a local FIFO, then one write burst out of it
// Bursts are clipped so neither side crosses a 4KB page; an error response aborts after the current transaction.
module dma_axi_ctrl #(
    parameter int MAX_BURST = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        dma_axi_start,
    input  logic [31:0] dma_cfg_saddr,
    input  logic [31:0] dma_cfg_daddr,
    input  logic [13:0] dma_cfg_number,
    output logic        dma_axi_done,
    output logic        dma_err,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [31:0] axi_araddr,
    output logic [7:0]  axi_arlen,
    output logic [2:0]  axi_arsize,
    output logic [1:0]  axi_arburst,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rlast,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_awaddr,
    output logic [7:0]  axi_awlen,
    output logic [2:0]  axi_awsize,
    output logic [1:0]  axi_awburst,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wlast,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    input  logic [1:0]  axi_bresp
);
    localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [13:0] rem_q, rem_d, len_q, len_d, beat_q, beat_d, len_c;
    logic        err_q, err_d, done_q, done_d;
    logic        start_acc, fifo_push;
    logic [10:0] rd_room, wr_room;
    logic [31:0] fifo_q [MAX_BURST];

    // Words left before each pointer reaches its next 4KB page
    always_comb begin
        rd_room = 11'd1024 - {1'b0, rd_ptr_q[11:2]};
        wr_room = 11'd1024 - {1'b0, wr_ptr_q[11:2]};
        len_c   = 14'(MAX_BURST);
        if (rem_q < len_c) len_c = rem_q;
        if ({3'b000, rd_room} < len_c) len_c = {3'b000, rd_room};
        if ({3'b000, wr_room} < len_c) len_c = {3'b000, wr_room};
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rem_d       = rem_q;
        len_d       = len_q;
        beat_d      = beat_q;
        err_d       = err_q;
        start_acc   = 1'b0;
        fifo_push   = 1'b0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_wlast   = 1'b0;
        axi_bready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dma_axi_start && done_q) begin
                    start_acc = 1'b1;
                    rd_ptr_d  = dma_cfg_saddr & 32'hFFFF_FFFC;
                    wr_ptr_d  = dma_cfg_daddr & 32'hFFFF_FFFC;
                    rem_d     = dma_cfg_number;
                    err_d     = 1'b0;
                    beat_d    = '0;
                    if (dma_cfg_number != 14'd0) state_d = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                axi_arvalid = 1'b1;
                len_d       = len_c;
                beat_d      = '0;
                if (axi_arready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                axi_rready = 1'b1;
                if (axi_rvalid) begin
                    // Surplus beats from a misbehaving slave are drained but never stored
                    fifo_push = (beat_q < len_q);
                    beat_d    = beat_q + 14'd1;
                    if (axi_rresp != 2'b00) err_d = 1'b1;
                    if (axi_rlast != (beat_q + 14'd1 == len_q)) err_d = 1'b1;
                    if (axi_rlast) begin
                        beat_d  = '0;
                        state_d = err_d ? S_IDLE : S_WR_ADDR;
                    end
                end
            end
            S_WR_ADDR: begin
                axi_awvalid = 1'b1;
                if (axi_awready) state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                axi_wvalid = 1'b1;
                axi_wlast  = (beat_q + 14'd1 == len_q);
                if (axi_wready) begin
                    beat_d = beat_q + 14'd1;
                    if (axi_wlast) begin
                        beat_d  = '0;
                        state_d = S_WR_RESP;
                    end
                end
            end
            S_WR_RESP: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    if (axi_bresp != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + {16'd0, len_q, 2'b00};
                        wr_ptr_d = wr_ptr_q + {16'd0, len_q, 2'b00};
                        rem_d    = rem_q - len_q;
                        state_d  = (rem_d == 14'd0) ? S_IDLE : S_RD_ADDR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Done is withheld for the cycle after an accepted start, even for zero-length requests
        done_d = (state_d == S_IDLE) && !start_acc;
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rem_q    <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rem_q    <= rem_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge hclk) begin
        if (fifo_push) fifo_q[beat_q[IW-1:0]] <= axi_rdata;
    end

    assign dma_axi_done = done_q;
    assign dma_err      = err_q;
    assign axi_araddr   = rd_ptr_q;
    assign axi_arlen    = 8'(len_c - 14'd1);
    assign axi_arsize   = 3'b010;
    assign axi_arburst  = 2'b01;
    assign axi_awaddr   = wr_ptr_q;
    assign axi_awlen    = 8'(len_q - 14'd1);
    assign axi_awsize   = 3'b010;
    assign axi_awburst  = 2'b01;
    assign axi_wdata    = fifo_q[beat_q[IW-1:0]];
    assign axi_wstrb    = 4'hF;

endmodule

// File: tb/tb_dma_axi_ctrl.sv
// tb/tb_dma_axi_ctrl.sv - scoreboard bench for dma_axi_ctrl with stalling AXI slave models
module tb_dma_axi_ctrl;
    localparam int MAXB = 16;

    logic        hclk, hreset, dma_axi_start, dma_axi_done, dma_err;
    logic [31:0] dma_cfg_saddr, dma_cfg_daddr;
    logic [13:0] dma_cfg_number;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
    logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
    logic [7:0]  axi_arlen, axi_awlen;
    logic [2:0]  axi_arsize, axi_awsize;
    logic [1:0]  axi_arburst, axi_awburst, axi_rresp, axi_bresp;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;

    dma_axi_ctrl #(.MAX_BURST(MAXB)) dut (
        .hclk(hclk), .hreset(hreset), .dma_axi_start(dma_axi_start),
        .dma_cfg_saddr(dma_cfg_saddr), .dma_cfg_daddr(dma_cfg_daddr), .dma_cfg_number(dma_cfg_number),
        .dma_axi_done(dma_axi_done), .dma_err(dma_err),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge hclk);
        cyc++;
    end

    typedef struct { logic [31:0] addr; logic [7:0] len; } ach_t;
    typedef struct { logic [31:0] data; logic last; } wbeat_t;
    ach_t   exp_ar[$];
    ach_t   exp_aw[$];
    wbeat_t exp_w[$];
    logic [31:0] dst [logic [31:0]];

    int n_tests = 0, n_fail = 0;
    int r_beats = 0, last_b_cyc = 0, exp_first_len = 0;
    bit inject_next = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int stall();
        return int'($urandom_range(0, 5));
    endfunction

    // Reference: chop the request into page-safe chunks of at most MAXB words
    task automatic plan(input logic [31:0] s, input logic [31:0] d, input int n, input bit first_only);
        int rem, len, sroom, droom;
        rem = n;
        exp_first_len = 0;
        while (rem > 0) begin
            sroom = (4096 - int'(s[11:0])) / 4;
            droom = (4096 - int'(d[11:0])) / 4;
            len = MAXB;
            if (rem < len) len = rem;
            if (sroom < len) len = sroom;
            if (droom < len) len = droom;
            if (exp_first_len == 0) exp_first_len = len;
            exp_ar.push_back('{s, 8'(len - 1)});
            if (first_only) break;
            exp_aw.push_back('{d, 8'(len - 1)});
            for (int i = 0; i < len; i++)
                exp_w.push_back('{src_word(s + 32'(4 * i)), i == len - 1});
            s += 32'(4 * len);
            d += 32'(4 * len);
            rem -= len;
        end
    endtask

    // Read slave: AR accept after a random stall, then rd_len beats each with a random gap
    logic [31:0] rd_addr;
    int rd_len, rd_beat, ar_wait, r_wait;
    bit rd_busy, r_hs_pend, rd_inject;
    initial begin
        axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0; axi_rlast = 0;
        rd_busy = 0; r_hs_pend = 0; rd_inject = 0; ar_wait = 0; r_wait = 0;
        rd_addr = 0; rd_len = 0; rd_beat = 0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                axi_arready = 0; axi_rvalid = 0; axi_rlast = 0; axi_rresp = 0;
                rd_busy = 0; r_hs_pend = 0;
            end else begin
                if (axi_arready) begin
                    axi_arready = 0; rd_busy = 1; rd_beat = 0; r_wait = stall();
                end else if (!rd_busy && axi_arvalid) begin
                    if (ar_wait == 0) begin
                        axi_arready = 1; rd_addr = axi_araddr; rd_len = int'(axi_arlen) + 1;
                        rd_inject = inject_next; inject_next = 0; ar_wait = stall();
                    end else ar_wait--;
                end
                if (r_hs_pend) begin
                    axi_rvalid = 0; axi_rlast = 0; axi_rresp = 0; r_hs_pend = 0;
                    rd_beat++;
                    if (rd_beat == rd_len) rd_busy = 0;
                    r_wait = stall();
                end
                if (rd_busy && !axi_rvalid) begin
                    if (r_wait == 0) begin
                        axi_rvalid = 1;
                        axi_rdata  = src_word(rd_addr + 32'(4 * rd_beat));
                        axi_rlast  = (rd_beat == rd_len - 1);
                        axi_rresp  = (rd_inject && rd_beat == 2) ? 2'b10 : 2'b00;
                        r_hs_pend  = axi_rready;
                    end else r_wait--;
                end
            end
        end
    end

    // Write slave: AW, W beats into dst memory, then B after a random stall
    logic [31:0] wr_addr;
    int wr_beat, aw_wait, w_wait, b_wait;
    bit wr_busy, b_pend, last_seen;
    initial begin
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
        wr_busy = 0; b_pend = 0; last_seen = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        wr_addr = 0; wr_beat = 0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
                wr_busy = 0; b_pend = 0;
            end else begin
                if (axi_awready) begin
                    axi_awready = 0; wr_busy = 1; wr_beat = 0;
                end else if (!wr_busy && !b_pend && !axi_bvalid && axi_awvalid) begin
                    if (aw_wait == 0) begin
                        axi_awready = 1; wr_addr = axi_awaddr; aw_wait = stall();
                    end else aw_wait--;
                end
                if (axi_wready) begin
                    axi_wready = 0; wr_beat++;
                    if (last_seen) begin wr_busy = 0; b_pend = 1; b_wait = stall(); end
                end else if (wr_busy && axi_wvalid) begin
                    if (w_wait == 0) begin
                        axi_wready = 1;
                        dst[wr_addr + 32'(4 * wr_beat)] = axi_wdata;
                        last_seen = axi_wlast; w_wait = stall();
                    end else w_wait--;
                end
                if (axi_bvalid) axi_bvalid = 0;
                else if (b_pend) begin
                    if (b_wait == 0) begin axi_bvalid = 1; axi_bresp = 2'b00; b_pend = 0; end
                    else b_wait--;
                end
            end
        end
    end

    // Monitor: one time unit before each rising edge, pop and compare on every handshake
    bit p_ar, p_aw, p_w;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [7:0]  p_arlen, p_awlen;
    logic        p_wlast;
    initial begin
        ach_t e;
        wbeat_t ew;
        p_ar = 0; p_aw = 0; p_w = 0;
        forever begin
            @(negedge hclk);
            #4;
            if (hreset) begin
                p_ar = 0; p_aw = 0; p_w = 0;
                continue;
            end
            if (axi_arvalid || axi_awvalid) check("ar_aw_exclusive", axi_arvalid && axi_awvalid, 0);
            if (p_ar) check("ar_hold", {axi_arvalid, axi_araddr, axi_arlen}, {1'b1, p_araddr, p_arlen});
            if (p_aw) check("aw_hold", {axi_awvalid, axi_awaddr, axi_awlen}, {1'b1, p_awaddr, p_awlen});
            if (p_w) check("w_hold", {axi_wvalid, axi_wdata, axi_wlast}, {1'b1, p_wdata, p_wlast});
            if (axi_arvalid && axi_arready) begin
                check("ar_expected", exp_ar.size() != 0, 1);
                if (exp_ar.size() != 0) begin
                    e = exp_ar.pop_front();
                    check("araddr", axi_araddr, e.addr);
                    check("arlen", axi_arlen, e.len);
                    check("ar_fixed", {axi_arsize, axi_arburst}, 5'b010_01);
                end
            end
            if (axi_awvalid && axi_awready) begin
                check("aw_expected", exp_aw.size() != 0, 1);
                if (exp_aw.size() != 0) begin
                    e = exp_aw.pop_front();
                    check("awaddr", axi_awaddr, e.addr);
                    check("awlen", axi_awlen, e.len);
                    check("aw_fixed", {axi_awsize, axi_awburst}, 5'b010_01);
                end
            end
            if (axi_wvalid && axi_wready) begin
                check("w_expected", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) begin
                    ew = exp_w.pop_front();
                    check("wdata", axi_wdata, ew.data);
                    check("wlast_wstrb", {axi_wlast, axi_wstrb}, {ew.last, 4'hF});
                end
            end
            if (axi_rvalid && axi_rready) r_beats++;
            if (axi_bvalid && axi_bready) last_b_cyc = cyc;
            p_ar = axi_arvalid && !axi_arready; p_araddr = axi_araddr; p_arlen = axi_arlen;
            p_aw = axi_awvalid && !axi_awready; p_awaddr = axi_awaddr; p_awlen = axi_awlen;
            p_w  = axi_wvalid && !axi_wready;   p_wdata = axi_wdata;   p_wlast = axi_wlast;
        end
    end

    task automatic issue_start(input logic [31:0] s, input logic [31:0] d, input int n);
        @(negedge hclk);
        dma_cfg_saddr = s; dma_cfg_daddr = d; dma_cfg_number = 14'(n);
        dma_axi_start = 1;
        @(negedge hclk);
        dma_axi_start = 0;
        dma_cfg_saddr = $urandom; dma_cfg_daddr = $urandom; dma_cfg_number = 14'($urandom);
        check("done_low_after_start", dma_axi_done, 0);
        check("err_cleared_by_start", dma_err, 0);
    endtask

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                            input bit inj, input bit poke);
        logic [31:0] sa, da, a;
        int k;
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        dst.delete();
        plan(sa, da, n, inj);
        r_beats = 0;
        inject_next = inj;
        issue_start(s, d, n);
        if (n == 0) begin
            @(negedge hclk);
            check("zero_len_done_back", dma_axi_done, 1);
        end else begin
            if (poke) begin
                repeat (6) @(negedge hclk);
                dma_axi_start = 1;
                @(negedge hclk);
                dma_axi_start = 0;
            end
            k = 0;
            while (!dma_axi_done && k < 20000) begin @(negedge hclk); k++; end
            check("done_timeout", dma_axi_done, 1);
            if (!inj) check("done_after_last_b", cyc, last_b_cyc + 1);
        end
        check("err_flag", dma_err, inj);
        check("queues_drained", exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
        if (inj) check("r_beats_drained", r_beats, exp_first_len);
        else for (int i = 0; i < n; i++) begin
            a = da + 32'(4 * i);
            check("dst_mem", dst.exists(a) ? dst[a] : 32'hDEAD_BEEF, src_word(sa + 32'(4 * i)));
        end
        repeat (2) @(negedge hclk);
    endtask

    initial begin
        int k;
        hreset = 1; dma_axi_start = 0;
        dma_cfg_saddr = 0; dma_cfg_daddr = 0; dma_cfg_number = 0;
        repeat (3) @(negedge hclk);
        check("reset_done", dma_axi_done, 1);
        check("reset_err", dma_err, 0);
        check("reset_handshakes", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 0);
        hreset = 0;

        run_xfer(32'h0000_1000, 32'h0000_2000, 40, 0, 1);
        run_xfer(32'h0000_0FF8, 32'h0000_3000, 5, 0, 0);
        run_xfer(32'h0000_0500, 32'h0000_0600, 0, 0, 0);
        run_xfer(32'h0000_1000, 32'h0000_2000, 40, 1, 1);
        run_xfer(32'h0000_1003, 32'h0000_2001, 100, 0, 1);
        run_xfer(32'hFFFF_FFF8, 32'h0000_7FF0, 6, 0, 0);
        for (int t = 0; t < 6; t++) begin
            int n;
            logic [31:0] s, d;
            n = int'($urandom_range(1, 100));
            s = (32'($urandom_range(0, 15)) << 12) + 32'($urandom_range(0, 4095));
            d = (32'($urandom_range(16, 31)) << 12) + 32'($urandom_range(0, 4095));
            run_xfer(s, d, n, 0, n >= 16);
        end

        plan(32'h0000_1000, 32'h0000_2000, 40, 0);
        issue_start(32'h0000_1000, 32'h0000_2000, 40);
        k = 0;
        while (!axi_wvalid && k < 3000) begin @(negedge hclk); k++; end
        check("reached_wr_data", axi_wvalid, 1);
        hreset = 1;
        @(negedge hclk);
        check("rst_mid_done", dma_axi_done, 1);
        check("rst_mid_wvalid", axi_wvalid, 0);
        check("rst_mid_err", dma_err, 0);
        @(negedge hclk);
        hreset = 0;
        exp_ar.delete(); exp_aw.delete(); exp_w.delete();
        run_xfer(32'h0000_4000, 32'h0000_5000, 4, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
